bp_be_superscalar_issue_fifo: RTL
=================================

# bp_be_superscalar_issue_fifo

Parametrised successor to the backend issue queue storage: a circular FIFO with speculative read pointer, commit checkpoint pointer and write pointer, generalised to configurable width, depth and multi-entry issue/commit per cycle. It sits between the FE queue interface and the backend decode/issue stage. It accepts one entry per cycle, exposes up to `issue_width_p` head entries combinationally, and supports roll-back to the checkpoint and full clear. It also reports occupancy and an almost-full credit signal.

## Interface
Parameters:
- `width_p`, 64, entry width in bits
- `els_p`, 16, entries; power of two, ≥ 2
- `issue_width_p`, 2, max entries read and max entries committed per cycle; 1 ≤ `issue_width_p` ≤ `els_p`
- `afull_slack_p`, 2, `almost_full_o` asserts when free slots ≤ `afull_slack_p`

Ports (`cnt_w` = clog2(`els_p`+1), `iw` = clog2(`issue_width_p`+1)):
- `clk_i` in 1: clock, all state on rising edge
- `reset_n_i` in 1: reset, asynchronous, active-low
- `clr_i` in 1: drop all contents, pointers to 0
- `suppress_i` in 1: block enqueue and head valids this cycle
- `data_i` in `width_p`: enqueue data
- `v_i` in 1: enqueue valid
- `ready_and_o` out 1: enqueue ready, equal to ~full & ~suppress_i & ~clr_i
- `data_o` out `issue_width_p`*`width_p`: slot k = entry at rptr+k
- `v_o` out `issue_width_p`: slot k valid
- `read_cnt_i` in `iw`: entries consumed speculatively (rptr advance)
- `commit_cnt_i` in `iw`: entries retired (cptr advance)
- `roll_i` in 1: rewind rptr to post-commit cptr
- `cnt_o` out `cnt_w`: wptr − cptr (total held)
- `spec_cnt_o` out `cnt_w`: wptr − rptr (unread)
- `empty_o` out 1: `spec_cnt_o` == 0
- `almost_full_o` out 1: `els_p` − `cnt_o` ≤ `afull_slack_p`

## Operation
- Three pointers wptr, rptr, cptr, each clog2(`els_p`)+1 bits. The MSB is the wrap bit. Arithmetic is modulo 2·`els_p`. Entry index = low bits.
- Invariant: cptr ≤ rptr ≤ wptr in modular distance. Full when wptr − cptr == `els_p`. Empty (speculative) when wptr == rptr.
- Storage: flop array of `els_p` × `width_p`. One write port, `issue_width_p` asynchronous read ports.
- Enqueue: on `v_i` & `ready_and_o`, write `data_i` at wptr, then wptr += 1.
- Head: `v_o[k]` = (k < `spec_cnt_o`) & ~`suppress_i`. `data_o` slot k is driven for all k, even when invalid.
- Read: effective read = min(`read_cnt_i`, `spec_cnt_o`), clamped. rptr += effective read.
- Commit: effective commit = min(`commit_cnt_i`, rptr − cptr), clamped. cptr += effective commit.
- Roll: rptr_next = cptr + effective commit. Any `read_cnt_i` in the same cycle is ignored. Enqueue in the same cycle proceeds normally.
- Clear: all pointers are 0 next cycle. Enqueue, read, commit and roll are ignored. `ready_and_o` is low during clr. Array contents are not cleared.
- Priority: clr > roll > read. Commit and enqueue are independent of roll.
- Full is computed against cptr, so speculatively read but uncommitted entries still occupy slots.

## Timing
- Reset values (asynchronous on `reset_n_i` low):
  - all pointers 0
  - `v_o` = 0, `empty_o` = 1, `cnt_o` = `spec_cnt_o` = 0
  - `almost_full_o` = (`els_p` ≤ `afull_slack_p`)
  - `ready_and_o` = ~`suppress_i`
  - reset deassertion mid-operation leaves the FIFO empty
- Enqueue-to-head latency is 1 cycle. An entry accepted in cycle t is visible on `v_o[0]` in t+1 if it is at the head. There is no same-cycle bypass.
- Read, commit, roll and clr take effect on the next rising edge. `data_o`/`v_o` reflect updated pointers in the following cycle.
- `ready_and_o`, `v_o` and `empty_o` depend combinationally on `suppress_i`/`clr_i` only. They do not depend on `v_i`, `read_cnt_i` or `commit_cnt_i`.
- An entry freed by commit in cycle t is usable for enqueue in t+1. There is no same-cycle full pass-through.
- Wrap-around: pointer MSB toggles each `els_p` entries, and multi-entry head reads wrap modulo `els_p`.

## Test plan
- Reset/fill/drain, `els_p`=16, `issue_width_p`=2:
  - enqueue 16 entries 0..15 → `ready_and_o`=0, `cnt_o`=16, `almost_full_o`=1 from `cnt_o`=14
  - read_cnt=2 ×8 plus commit_cnt=2 ×8 → `cnt_o`=0, data order 0..15 in slot pairs
- Wrap: enqueue 24 and read/commit interleaved → `data_o` slot1 across index 15→0 matches the enqueued sequence, and pointer MSB toggles.
- Roll: enqueue A..E, read 2 (A,B), read 2 (C,D), commit 1 with roll in the same cycle → next cycle head = B,C, `spec_cnt_o`=4, `cnt_o`=4.
- Full on uncommitted: fill 16, read all 16 without commit → `ready_and_o`=0. Commit 1 → `ready_and_o`=1 in the next cycle.
- Clamp/suppress:
  - `spec_cnt_o`=1 with read_cnt=2 → rptr += 1, `empty_o`=1
  - `suppress_i`=1 → `v_o`=0 and `ready_and_o`=0, with pointers unchanged
- Clear with simultaneous enqueue, read and roll → all counts 0 next cycle and the enqueued data is not visible. Asynchronous reset asserted mid-burst → outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/bp_be_superscalar_issue_fifo_if.sv
// ---------------------------------------------------------------------------
// bp_be_superscalar_issue_fifo_if
//
// Purpose: bundles every non-clock/non-reset signal of the superscalar issue
// FIFO. Signal names keep the FIFO-side direction suffix (_i = into the FIFO,
// _o = out of the FIFO).
//
// Handshake (enqueue side): an entry is transferred on a rising edge when
// v_i and ready_and_o are both high in the cycle before it. ready_and_o never
// depends on v_i, so the producer may raise v_i after looking at ready_and_o.
// Head side: v_o[k] marks slot k of data_o as holding a real entry. The
// consumer reports how many head entries it took via read_cnt_i and how many
// it retired via commit_cnt_i. Both counts are clamped inside the FIFO.
//
// Signals:
//   clr_i, suppress_i, roll_i    control inputs
//   data_i, v_i, ready_and_o     enqueue handshake
//   data_o, v_o                  issue_width_p head slots
//   read_cnt_i, commit_cnt_i     speculative read / commit counts
//   cnt_o, spec_cnt_o, empty_o,  occupancy status
//   almost_full_o
//   wptr_o, rptr_o, cptr_o       raw pointer values (wrap bit is the MSB)
//
// Modports: master = producer/consumer side, slave = the FIFO.
// ---------------------------------------------------------------------------
interface bp_be_superscalar_issue_fifo_if #(
    parameter int width_p       = 64,
    parameter int els_p         = 16,
    parameter int issue_width_p = 2
);
    localparam int cnt_w = $clog2(els_p + 1);
    localparam int iw_w  = $clog2(issue_width_p + 1);
    localparam int ptr_w = $clog2(els_p) + 1;

    logic                             clr_i;
    logic                             suppress_i;
    logic [width_p-1:0]               data_i;
    logic                             v_i;
    logic                             ready_and_o;
    logic [issue_width_p*width_p-1:0] data_o;
    logic [issue_width_p-1:0]         v_o;
    logic [iw_w-1:0]                  read_cnt_i;
    logic [iw_w-1:0]                  commit_cnt_i;
    logic                             roll_i;
    logic [cnt_w-1:0]                 cnt_o;
    logic [cnt_w-1:0]                 spec_cnt_o;
    logic                             empty_o;
    logic                             almost_full_o;
    logic [ptr_w-1:0]                 wptr_o;
    logic [ptr_w-1:0]                 rptr_o;
    logic [ptr_w-1:0]                 cptr_o;

    modport master (
        output clr_i, suppress_i, data_i, v_i, read_cnt_i, commit_cnt_i, roll_i,
        input  ready_and_o, data_o, v_o, cnt_o, spec_cnt_o, empty_o, almost_full_o,
        input  wptr_o, rptr_o, cptr_o
    );

    modport slave (
        input  clr_i, suppress_i, data_i, v_i, read_cnt_i, commit_cnt_i, roll_i,
        output ready_and_o, data_o, v_o, cnt_o, spec_cnt_o, empty_o, almost_full_o,
        output wptr_o, rptr_o, cptr_o
    );
endinterface

// File: rtl/bp_be_superscalar_issue_fifo.sv
// ---------------------------------------------------------------------------
// bp_be_superscalar_issue_fifo
//
// Purpose: circular issue queue between the FE queue and backend issue.
// Three pointers (write, speculative read, commit checkpoint) share one flop
// array. The head exposes issue_width_p entries combinationally. The read
// pointer can be rolled back to the checkpoint, and the whole queue can be
// cleared.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   reset_n_i  asynchronous active-low reset
//   io         bp_be_superscalar_issue_fifo_if.slave (handshake, head, status)
//
// Parameters must match those of the connected interface instance:
// els_p is a power of two >= 2, and 1 <= issue_width_p <= els_p.
// ---------------------------------------------------------------------------
module bp_be_superscalar_issue_fifo #(
    parameter int width_p       = 64,
    parameter int els_p         = 16,
    parameter int issue_width_p = 2,
    parameter int afull_slack_p = 2
) (
    input logic                           clk_i,
    input logic                           reset_n_i,
    bp_be_superscalar_issue_fifo_if.slave io
);
    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;           // extra MSB is the wrap bit
    localparam int cnt_w = $clog2(els_p + 1);   // equals ptr_w for power-of-two depth

    // Pointer state
    logic [ptr_w-1:0] wptr_q, wptr_d;
    logic [ptr_w-1:0] rptr_q, rptr_d;
    logic [ptr_w-1:0] cptr_q, cptr_d;

    // Storage: written only through wptr. Contents are never reset or cleared,
    // because pointer state alone decides what is visible.
    logic [width_p-1:0] mem_q [els_p];

    // Distances between pointers. Modular subtraction on ptr_w bits gives the
    // true distance because no distance can exceed els_p.
    logic [ptr_w-1:0] held;        // wptr - cptr: all occupied slots
    logic [ptr_w-1:0] unread;      // wptr - rptr: not yet read speculatively
    logic [ptr_w-1:0] inflight;    // rptr - cptr: read but not committed
    logic [ptr_w-1:0] free_slots;

    logic [ptr_w-1:0] read_req;
    logic [ptr_w-1:0] commit_req;
    logic [ptr_w-1:0] eff_read;
    logic [ptr_w-1:0] eff_commit;

    logic full;
    logic ready;
    logic enq;

    // -----------------------------------------------------------------------
    // Occupancy, handshake and clamped counts
    // -----------------------------------------------------------------------
    always_comb begin
        held       = wptr_q - cptr_q;
        unread     = wptr_q - rptr_q;
        inflight   = rptr_q - cptr_q;
        free_slots = ptr_w'(els_p) - held;

        // Full is measured from the commit pointer. Entries that were read
        // but not yet committed still occupy their slots until retired.
        full  = (held == ptr_w'(els_p));
        ready = ~full & ~io.suppress_i & ~io.clr_i;
        enq   = io.v_i & ready;

        // The consumer may ask for more than is available. Clamp so that
        // cptr <= rptr <= wptr always holds.
        read_req   = ptr_w'(io.read_cnt_i);
        commit_req = ptr_w'(io.commit_cnt_i);
        eff_read   = (read_req < unread)     ? read_req   : unread;
        eff_commit = (commit_req < inflight) ? commit_req : inflight;
    end

    // -----------------------------------------------------------------------
    // Next-state pointers. Priority is clr > roll > read. Commit and enqueue
    // do not depend on roll.
    // -----------------------------------------------------------------------
    always_comb begin
        wptr_d = wptr_q + ptr_w'(enq);
        cptr_d = cptr_q + eff_commit;
        // A roll rewinds to the checkpoint after this cycle's commit is
        // applied, and any read in the same cycle is discarded.
        rptr_d = io.roll_i ? (cptr_q + eff_commit) : (rptr_q + eff_read);

        if (io.clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Single write port. enq is already low during clr and when full.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q[idx_w-1:0]] <= io.data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Head slots: slot k is the entry at rptr+k. The index wraps naturally
    // because it is idx_w bits wide. Data is driven whether or not the slot
    // is valid.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < issue_width_p; k++) begin : g_head
        logic [idx_w-1:0] slot_idx;
        assign slot_idx = rptr_q[idx_w-1:0] + idx_w'(k);
        assign io.data_o[k*width_p +: width_p] = mem_q[slot_idx];
        assign io.v_o[k] = (ptr_w'(k) < unread) & ~io.suppress_i;
    end

    // -----------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------
    assign io.ready_and_o   = ready;
    assign io.cnt_o         = cnt_w'(held);
    assign io.spec_cnt_o    = cnt_w'(unread);
    assign io.empty_o       = (unread == '0);
    assign io.almost_full_o = (int'(free_slots) <= afull_slack_p);
    assign io.wptr_o        = wptr_q;
    assign io.rptr_o        = rptr_q;
    assign io.cptr_o        = cptr_q;

endmodule
